mem_apb_arbiter: RTL

MEM_APB_ARBITER -- requirements
Module: mem_apb_arbiter

---
 rtl/mem_apb_pkg.sv | 13 +
 rtl/rr_arb2.sv | 19 +
 rtl/mem_apb_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/mem_apb_pkg.sv
// Shared definitions for the two-requester APB memory arbiter.
package mem_apb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_apb_arbiter.sv
// Arbitrates two request/done clients onto a single APB master port.
module mem_apb_arbiter
  import mem_apb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  apb_state_e        state;
  logic              owner;     // requester granted last; also owns the current transfer
  logic [1:0]        grant;
  logic              win;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_rr_arb2 (
    .req   ({req1, req0}),
    .last  (owner),
    .grant (grant)
  );

  always_comb begin
    win       = (grant == 2'b10);
    win_wr    = win ? wr1 : wr0;
    win_addr  = win ? addr1 : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state  <= ST_IDLE;
      owner  <= 1'b1;
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata  <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            state  <= ST_SETUP;
            owner  <= win;
            paddr  <= win_addr;
            pwrite <= win_wr;
            pwdata <= win_wr ? win_wdata : '0;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          if (pready) begin
            state <= ST_IDLE;
            done0 <= ~owner;
            done1 <= owner;
            if (!pwrite) rdata <= prdata;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign psel    = (state != ST_IDLE);
  assign penable = (state == ST_ACCESS);
  assign busy    = (state != ST_IDLE);

endmodule
